// File: rtl/em_mac_acc.sv
// -----------------------------------------------------------------------------
// em_mac_acc -- dual 40-bit multiply-accumulate register file with saturation.
//
// A two-stage pipeline that sits behind the E-stage product adder.
// Stage W latches the rounded product and its control. Stage X combines the
// latched product with the target accumulator and writes the result back.
// Overflow is detected at 41 bits. It either saturates or wraps, and it always
// sets the accumulator's sticky flag.
//
// Ports
//   CLK         in   1   clock, all state on rising edge
//   RST         in   1   synchronous active-high reset
//   MACin_E     in  40   rounded two's-complement product
//   op_valid_E  in   1   product/control valid this cycle
//   acc_op_E    in   2   00 MPY, 01 MAC, 10 MSU, 11 CLR
//   acc_sel_E   in   1   target accumulator (0 = A0, 1 = A1)
//   sat_en_E    in   1   saturate on overflow for this op
//   hold_E      in   1   pipeline stall; freezes all state
//   rd_sel      in   1   accumulator shown on ACC_out / SAT_out
//   ACC_out     out 40   selected accumulator
//   SAT_out     out 32   selected accumulator saturated to 32 bits
//   ovf_sticky  out  2   sticky overflow flags, bit 0 = A0, bit 1 = A1
//   res_valid   out  1   one-cycle pulse after each accumulator write
// -----------------------------------------------------------------------------
module em_mac_acc (
    input  logic               CLK,
    input  logic               RST,
    input  logic signed [39:0] MACin_E,
    input  logic               op_valid_E,
    input  logic [1:0]         acc_op_E,
    input  logic               acc_sel_E,
    input  logic               sat_en_E,
    input  logic               hold_E,
    input  logic               rd_sel,
    output logic signed [39:0] ACC_out,
    output logic signed [31:0] SAT_out,
    output logic [1:0]         ovf_sticky,
    output logic               res_valid
);

    localparam logic [1:0] OP_MPY = 2'b00;
    localparam logic [1:0] OP_MAC = 2'b01;
    localparam logic [1:0] OP_MSU = 2'b10;
    localparam logic [1:0] OP_CLR = 2'b11;

    localparam logic signed [39:0] ACC_MAX = 40'sh7F_FFFF_FFFF;
    localparam logic signed [39:0] ACC_MIN = 40'sh80_0000_0000;
    localparam logic signed [31:0] S32_MAX = 32'sh7FFF_FFFF;
    localparam logic signed [31:0] S32_MIN = 32'sh8000_0000;

    // Clamp a 41-bit MAC/MSU result to the 40-bit range. The sign of the
    // out-of-range value is bit 40.
    function automatic logic signed [39:0] sat40(input logic signed [40:0] r);
        if (r[40] != r[39])
            sat40 = r[40] ? ACC_MIN : ACC_MAX;
        else
            sat40 = r[39:0];
    endfunction

    // 32-bit view: the value fits when the guard bits 39:31 all agree.
    function automatic logic signed [31:0] sat32(input logic signed [39:0] a);
        if ((&a[39:31]) || !(|a[39:31]))
            sat32 = a[31:0];
        else
            sat32 = a[39] ? S32_MIN : S32_MAX;
    endfunction

    logic signed [39:0] p_p0;
    logic [1:0]         op_p0;
    logic               sel_p0;
    logic               sat_p0;
    logic               vld_p0;

    logic signed [39:0] acc_a0;
    logic signed [39:0] acc_a1;
    logic [1:0]         ovf_q;
    logic               vld_p1;

    logic signed [39:0] acc_cur;
    logic signed [40:0] sum_x;
    logic signed [40:0] dif_x;
    logic signed [40:0] res_x;
    logic signed [39:0] acc_nxt;
    logic               ovf_x;
    logic               wr_x;

    // ---------------- Stage W: capture product and control ----------------
    always_ff @(posedge CLK) begin
        if (RST)
            vld_p0 <= 1'b0;
        else if (!hold_E)
            vld_p0 <= op_valid_E;
    end

    always_ff @(posedge CLK) begin
        if (!hold_E && op_valid_E) begin
            p_p0   <= MACin_E;
            op_p0  <= acc_op_E;
            sel_p0 <= acc_sel_E;
            sat_p0 <= sat_en_E;
        end
    end

    // ---------------- Stage X: combine with accumulator, write back -------
    // The registered accumulator is always current here, because a write lands
    // on the same edge that advances the next op into this stage.
    always_comb begin
        acc_cur = sel_p0 ? acc_a1 : acc_a0;
        sum_x   = {acc_cur[39], acc_cur} + {p_p0[39], p_p0};
        dif_x   = {acc_cur[39], acc_cur} - {p_p0[39], p_p0};
        res_x   = sum_x;
        acc_nxt = p_p0;
        ovf_x   = 1'b0;
        case (op_p0)
            OP_MPY: acc_nxt = p_p0;
            OP_MAC: res_x   = sum_x;
            OP_MSU: res_x   = dif_x;
            OP_CLR: acc_nxt = '0;
            default: acc_nxt = p_p0;
        endcase
        if (op_p0 == OP_MAC || op_p0 == OP_MSU) begin
            ovf_x   = res_x[40] ^ res_x[39];
            acc_nxt = sat_p0 ? sat40(res_x) : res_x[39:0];
        end
        wr_x = vld_p0 && !hold_E;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            acc_a0 <= '0;
            acc_a1 <= '0;
            ovf_q  <= 2'b00;
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= wr_x;
            if (wr_x) begin
                if (sel_p0)
                    acc_a1 <= acc_nxt;
                else
                    acc_a0 <= acc_nxt;
                if (op_p0 == OP_CLR)
                    ovf_q[sel_p0] <= 1'b0;
                else if (ovf_x)
                    ovf_q[sel_p0] <= 1'b1;
            end
        end
    end

    // ---------------- Read port: registered state only, no bypass --------
    assign ACC_out    = rd_sel ? acc_a1 : acc_a0;
    assign SAT_out    = sat32(ACC_out);
    assign ovf_sticky = ovf_q;
    assign res_valid  = vld_p1;

endmodule

// File: tb/tb_em_mac_acc.sv
module tb_em_mac_acc;

    logic        CLK = 1'b0;
    logic        RST;
    logic [39:0] MACin_E;
    logic        op_valid_E;
    logic [1:0]  acc_op_E;
    logic        acc_sel_E;
    logic        sat_en_E;
    logic        hold_E;
    logic        rd_sel;
    logic [39:0] ACC_out;
    logic [31:0] SAT_out;
    logic [1:0]  ovf_sticky;
    logic        res_valid;

    int total = 0;
    int bad   = 0;

    em_mac_acc dut (
        .CLK        (CLK),
        .RST        (RST),
        .MACin_E    (MACin_E),
        .op_valid_E (op_valid_E),
        .acc_op_E   (acc_op_E),
        .acc_sel_E  (acc_sel_E),
        .sat_en_E   (sat_en_E),
        .hold_E     (hold_E),
        .rd_sel     (rd_sel),
        .ACC_out    (ACC_out),
        .SAT_out    (SAT_out),
        .ovf_sticky (ovf_sticky),
        .res_valid  (res_valid)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [1:0]  op;
        logic        sel;
        logic        sat;
        logic [39:0] p;
        logic        rd;
        logic [39:0] exp_acc;
        logic [31:0] exp_sat;
        logic [1:0]  exp_ovf;
    } vec_t;

    vec_t tbl[16];

    task automatic step;
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic chk(input string nm, input logic [39:0] act, input logic [39:0] exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp_v);
        end
    endtask

    // Issue one op, then check the write two edges later.
    task automatic run_op(input logic [1:0] op, input logic sel, input logic sat,
                          input logic [39:0] p, input logic rd,
                          input logic [39:0] ea, input logic [31:0] es,
                          input logic [1:0] eo, input string nm);
        MACin_E    = p;
        acc_op_E   = op;
        acc_sel_E  = sel;
        sat_en_E   = sat;
        rd_sel     = rd;
        op_valid_E = 1'b1;
        step;
        op_valid_E = 1'b0;
        chk({nm, " rv_idle"}, {39'd0, res_valid}, 40'd0);
        step;
        chk({nm, " rv"},  {39'd0, res_valid}, 40'd1);
        chk({nm, " acc"}, ACC_out, ea);
        chk({nm, " sat"}, {8'd0, SAT_out}, {8'd0, es});
        chk({nm, " ovf"}, {38'd0, ovf_sticky}, {38'd0, eo});
    endtask

    initial begin
        tbl[0]  = '{2'b00, 1'b0, 1'b0, 40'h00_0000_0005, 1'b0, 40'h00_0000_0005, 32'h0000_0005, 2'b00};
        tbl[1]  = '{2'b01, 1'b0, 1'b1, 40'h00_0000_0003, 1'b0, 40'h00_0000_0008, 32'h0000_0008, 2'b00};
        tbl[2]  = '{2'b10, 1'b0, 1'b0, 40'h00_0000_000A, 1'b0, 40'hFF_FFFF_FFFE, 32'hFFFF_FFFE, 2'b00};
        tbl[3]  = '{2'b00, 1'b0, 1'b0, 40'h7F_FFFF_FFF0, 1'b0, 40'h7F_FFFF_FFF0, 32'h7FFF_FFFF, 2'b00};
        tbl[4]  = '{2'b01, 1'b0, 1'b1, 40'h00_0000_0020, 1'b0, 40'h7F_FFFF_FFFF, 32'h7FFF_FFFF, 2'b01};
        tbl[5]  = '{2'b00, 1'b0, 1'b0, 40'h7F_FFFF_FFF0, 1'b0, 40'h7F_FFFF_FFF0, 32'h7FFF_FFFF, 2'b01};
        tbl[6]  = '{2'b01, 1'b0, 1'b0, 40'h00_0000_0020, 1'b0, 40'h80_0000_0010, 32'h8000_0000, 2'b01};
        tbl[7]  = '{2'b11, 1'b0, 1'b0, 40'h12_3456_789A, 1'b0, 40'h00_0000_0000, 32'h0000_0000, 2'b00};
        tbl[8]  = '{2'b00, 1'b1, 1'b0, 40'h01_0000_0000, 1'b1, 40'h01_0000_0000, 32'h7FFF_FFFF, 2'b00};
        tbl[9]  = '{2'b00, 1'b1, 1'b0, 40'hFF_8000_0000, 1'b1, 40'hFF_8000_0000, 32'h8000_0000, 2'b00};
        tbl[10] = '{2'b00, 1'b1, 1'b0, 40'h80_0000_0000, 1'b1, 40'h80_0000_0000, 32'h8000_0000, 2'b00};
        tbl[11] = '{2'b10, 1'b1, 1'b1, 40'h00_0000_0001, 1'b1, 40'h80_0000_0000, 32'h8000_0000, 2'b10};
        tbl[12] = '{2'b00, 1'b0, 1'b0, 40'hFF_FFFF_FFFF, 1'b0, 40'hFF_FFFF_FFFF, 32'hFFFF_FFFF, 2'b10};
        tbl[13] = '{2'b10, 1'b0, 1'b0, 40'hFF_FFFF_FFFF, 1'b0, 40'h00_0000_0000, 32'h0000_0000, 2'b10};
        tbl[14] = '{2'b10, 1'b0, 1'b0, 40'h80_0000_0000, 1'b0, 40'h80_0000_0000, 32'h8000_0000, 2'b11};
        tbl[15] = '{2'b01, 1'b1, 1'b0, 40'h00_0000_0000, 1'b1, 40'h80_0000_0000, 32'h8000_0000, 2'b11};

        RST = 1'b1; MACin_E = '0; op_valid_E = 1'b0; acc_op_E = 2'b00;
        acc_sel_E = 1'b0; sat_en_E = 1'b0; hold_E = 1'b0; rd_sel = 1'b0;
        @(negedge CLK);
        step; step;
        RST = 1'b0;
        step;
        chk("rst acc0", ACC_out, 40'd0);
        chk("rst sat0", {8'd0, SAT_out}, 40'd0);
        chk("rst ovf",  {38'd0, ovf_sticky}, 40'd0);
        chk("rst rv",   {39'd0, res_valid}, 40'd0);
        rd_sel = 1'b1;
        chk("rst acc1", ACC_out, 40'd0);
        rd_sel = 1'b0;

        // Back-to-back MPY then MAC into A0.
        MACin_E = 40'd5; acc_op_E = 2'b00; acc_sel_E = 1'b0; op_valid_E = 1'b1;
        step;
        MACin_E = 40'd3; acc_op_E = 2'b01;
        step;
        op_valid_E = 1'b0;
        chk("b2b first rv",  {39'd0, res_valid}, 40'd1);
        chk("b2b first acc", ACC_out, 40'd5);
        step;
        chk("b2b second rv",  {39'd0, res_valid}, 40'd1);
        chk("b2b second acc", ACC_out, 40'd8);
        step;
        chk("b2b rv drop", {39'd0, res_valid}, 40'd0);

        for (int i = 0; i < 16; i++)
            run_op(tbl[i].op, tbl[i].sel, tbl[i].sat, tbl[i].p, tbl[i].rd,
                   tbl[i].exp_acc, tbl[i].exp_sat, tbl[i].exp_ovf,
                   $sformatf("vec%0d", i));

        // Hold: MAC into A0 (currently 0x80_0000_0000) stalls for 3 cycles; a
        // competing op presented during the hold must be ignored.
        rd_sel = 1'b0;
        MACin_E = 40'h10; acc_op_E = 2'b01; acc_sel_E = 1'b0; sat_en_E = 1'b0;
        op_valid_E = 1'b1;
        step;
        hold_E = 1'b1;
        MACin_E = 40'h999; acc_op_E = 2'b00;
        for (int k = 0; k < 3; k++) begin
            step;
            chk($sformatf("hold%0d acc", k), ACC_out, 40'h80_0000_0000);
            chk($sformatf("hold%0d rv", k), {39'd0, res_valid}, 40'd0);
        end
        hold_E = 1'b0;
        op_valid_E = 1'b0;
        step;
        chk("hold release acc", ACC_out, 40'h80_0000_0010);
        chk("hold release rv",  {39'd0, res_valid}, 40'd1);
        step;
        chk("hold after acc", ACC_out, 40'h80_0000_0010);
        chk("hold after rv",  {39'd0, res_valid}, 40'd0);

        // Reset while a MAC to A1 is in stage X.
        rd_sel = 1'b1;
        MACin_E = 40'd5; acc_op_E = 2'b01; acc_sel_E = 1'b1; op_valid_E = 1'b1;
        step;
        op_valid_E = 1'b0;
        RST = 1'b1;
        step;
        chk("midrst acc1", ACC_out, 40'd0);
        chk("midrst rv",   {39'd0, res_valid}, 40'd0);
        chk("midrst ovf",  {38'd0, ovf_sticky}, 40'd0);
        RST = 1'b0;
        step;
        chk("postrst acc1", ACC_out, 40'd0);
        chk("postrst rv",   {39'd0, res_valid}, 40'd0);

        // Set A0 sticky, then clear it with CLR.
        run_op(2'b00, 1'b0, 1'b0, 40'h7F_FFFF_FFF0, 1'b0, 40'h7F_FFFF_FFF0, 32'h7FFF_FFFF, 2'b00, "ovf load");
        run_op(2'b01, 1'b0, 1'b1, 40'h00_0000_0020, 1'b0, 40'h7F_FFFF_FFFF, 32'h7FFF_FFFF, 2'b01, "ovf set");
        run_op(2'b11, 1'b0, 1'b0, 40'h00_0000_0000, 1'b0, 40'h00_0000_0000, 32'h0000_0000, 2'b00, "clr a0");
        step;
        chk("final rv", {39'd0, res_valid}, 40'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
